// File: rtl/mem_write_controller_pkg.sv
// mem_write_controller_pkg: shared DAQ constants for the readout side and the memory-write side.
package mem_write_controller_pkg;

  localparam int unsigned DAQ_WORD_BITS  = 32;
  localparam int unsigned DAQ_ADDR_BITS  = 30;
  localparam int unsigned DAQ_COUNT_BITS = 24;

  localparam int unsigned RO_CHANNELS    = 8;
  localparam int unsigned RO_SAMPLE_BITS = 12;

  localparam int unsigned DEF_ADDR_STEP  = 4;
  localparam int unsigned DEF_MAX_ADDR   = 16777212;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_WRITE,
    S_WRITE_WAIT,
    S_FINISH
  } wr_state_e;

  function automatic logic [DAQ_ADDR_BITS-1:0] clamp_addr(
    input logic [DAQ_ADDR_BITS-1:0] addr,
    input logic [DAQ_ADDR_BITS-1:0] lim
  );
    return addr > lim ? lim : addr;
  endfunction

endpackage

// File: rtl/mem_write_controller_fifo.sv
// sync_word_fifo: single-clock word FIFO; a push into a full FIFO is taken only when a pop frees a slot.
module sync_word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_comb begin
    empty   = wptr_q == rptr_q;
    full    = wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]};
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = clr ? '0 : wptr_q + {{AW{1'b0}}, do_push};
    rptr_d  = clr ? '0 : rptr_q + {{AW{1'b0}}, do_pop};
    rdata   = mem[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mem_write_controller.sv
// mem_write_controller: buffers strobed data words and writes them to a memory port over an address range.
module mem_write_controller
  import mem_write_controller_pkg::*;
#(
  parameter int unsigned ADDR_STEP  = DEF_ADDR_STEP,
  parameter int unsigned MAX_ADDR   = DEF_MAX_ADDR,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cntrlWriteData,
  input  logic        cntrlAbort,
  input  logic [29:0] writeAddrStart,
  input  logic [29:0] writeAddrEnd,
  input  logic [31:0] rx_data_in,
  input  logic        rx_data_ready,
  input  logic        pX_ready,
  output logic [31:0] pX_data_out,
  output logic [29:0] pX_addr,
  output logic        pX_read_write,
  output logic        pX_mem_op,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [23:0] wordCount
);

  wr_state_e   state_q, state_d;
  logic [30:0] addr_q, addr_d;
  logic [29:0] end_q, end_d;
  logic [31:0] data_q, data_d;
  logic [23:0] count_q, count_d;
  logic        mem_op_q, mem_op_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        overflow_q, overflow_d;
  logic        start, finish, advance;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0] fifo_rdata;

  sync_word_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (rx_data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // addr_q keeps a carry bit so stepping past 2^30 still compares above the end address.
  always_comb begin
    start      = state_q == S_IDLE && cntrlWriteData;
    finish     = state_q == S_WAIT_DATA && (addr_q > {1'b0, end_q} || cntrlAbort);
    fifo_pop   = state_q == S_WAIT_DATA && !finish && !fifo_empty && pX_ready;
    advance    = state_q == S_WRITE_WAIT && !mem_op_q && pX_ready;
    fifo_push  = busy_q && rx_data_ready;
    state_d    = start                ? S_WAIT_DATA
               : finish               ? S_FINISH
               : fifo_pop             ? S_WRITE
               : state_q == S_WRITE   ? S_WRITE_WAIT
               : advance              ? S_WAIT_DATA
               : state_q == S_FINISH  ? S_IDLE
               : state_q;
    addr_d     = start ? {1'b0, writeAddrStart} : advance ? addr_q + 31'(ADDR_STEP) : addr_q;
    end_d      = start ? clamp_addr(writeAddrEnd, 30'(MAX_ADDR)) : end_q;
    data_d     = fifo_pop ? fifo_rdata : data_q;
    count_d    = start ? '0 : advance ? count_q + 24'd1 : count_q;
    overflow_d = !start && (overflow_q || (fifo_push && fifo_full && !fifo_pop));
    mem_op_d   = state_d == S_WRITE || (state_d == S_WRITE_WAIT && state_q == S_WRITE);
    busy_d     = state_d != S_IDLE;
    done_d     = state_d == S_FINISH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      end_q      <= '0;
      data_q     <= '0;
      count_q    <= '0;
      mem_op_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      end_q      <= end_d;
      data_q     <= data_d;
      count_q    <= count_d;
      mem_op_q   <= mem_op_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign pX_addr       = addr_q[29:0];
  assign pX_data_out   = data_q;
  assign pX_mem_op     = mem_op_q;
  assign pX_read_write = ~mem_op_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow      = overflow_q;
  assign wordCount     = count_q;

endmodule

// File: tb/tb_mem_write_controller.sv
// tb_mem_write_controller: scoreboard bench; expected writes are queued at stimulus time and checked by a monitor.
module tb_mem_write_controller;

  localparam longint STEP = 4;
  localparam longint MAXA = 16777212;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cntrlWriteData = 1'b0;
  logic        cntrlAbort = 1'b0;
  logic [29:0] writeAddrStart = '0;
  logic [29:0] writeAddrEnd = '0;
  logic [31:0] rx_data_in = '0;
  logic        rx_data_ready = 1'b0;
  logic        pX_ready;
  logic [31:0] pX_data_out;
  logic [29:0] pX_addr;
  logic        pX_read_write;
  logic        pX_mem_op;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [23:0] wordCount;

  mem_write_controller #(
    .ADDR_STEP(4),
    .MAX_ADDR(16777212),
    .FIFO_DEPTH(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cntrlWriteData (cntrlWriteData),
    .cntrlAbort     (cntrlAbort),
    .writeAddrStart (writeAddrStart),
    .writeAddrEnd   (writeAddrEnd),
    .rx_data_in     (rx_data_in),
    .rx_data_ready  (rx_data_ready),
    .pX_ready       (pX_ready),
    .pX_data_out    (pX_data_out),
    .pX_addr        (pX_addr),
    .pX_read_write  (pX_read_write),
    .pX_mem_op      (pX_mem_op),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .wordCount      (wordCount)
  );

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] words[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          writes_seen = 0;
  int          dones_seen = 0;
  logic        ready_set = 1'b1;
  logic        rnd_ready = 1'b0;

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pX_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      pX_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_set;
    end
  end

  initial begin
    logic        prv;
    int          len;
    wr_t         e;
    logic [29:0] ca;
    logic [31:0] cd;
    prv = 1'b0;
    len = 0;
    ca = '0;
    cd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prv = 1'b0;
        len = 0;
      end else begin
        if (done) dones_seen++;
        if (pX_mem_op && !prv) begin
          writes_seen++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with none outstanding", pX_addr, pX_data_out);
          end else begin
            e = exp_q.pop_front();
            check("write_addr", 64'(pX_addr), 64'(e.a));
            check("write_data", 64'(pX_data_out), 64'(e.d));
          end
          check("write_rw", 64'(pX_read_write), 64'(0));
          ca = pX_addr;
          cd = pX_data_out;
          len = 1;
        end else if (pX_mem_op) begin
          len++;
          check("write_stable", 64'({pX_addr, pX_data_out, pX_read_write}), 64'({ca, cd, 1'b0}));
        end else if (prv) begin
          check("mem_op_cycles", 64'(len), 64'(2));
          check("rw_after_op", 64'(pX_read_write), 64'(1));
        end
        prv = pX_mem_op;
      end
    end
  end

  // Number of words a run covers: inclusive range after clamping, in ADDR_STEP increments.
  function automatic int exp_count(input longint s, input longint e);
    longint ec;
    ec = e > MAXA ? MAXA : e;
    return ec < s ? 0 : int'((ec - s) / STEP + 1);
  endfunction

  task automatic predict(input longint s, input longint e, input int limit, output int n);
    wr_t w;
    n = exp_count(s, e);
    if (n > words.size()) n = words.size();
    if (n > limit) n = limit;
    for (int i = 0; i < n; i++) begin
      w.a = 30'(s + longint'(i) * STEP);
      w.d = words[i];
      exp_q.push_back(w);
    end
  endtask

  task automatic start_run(input logic [29:0] s, input logic [29:0] e);
    writeAddrStart = s;
    writeAddrEnd = e;
    cntrlWriteData = 1'b1;
    tick();
    cntrlWriteData = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    rx_data_in = d;
    rx_data_ready = 1'b1;
    tick();
    rx_data_ready = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input int d0);
    for (int k = 0; k < budget && dones_seen == d0; k++) tick();
    if (dones_seen == d0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_done_timeout: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic finish_checks(input string name, input int n, input logic ovf, input int d0);
    repeat (3) tick();
    check({name, "_done_pulses"}, 64'(dones_seen - d0), 64'(1));
    check({name, "_wordCount"}, 64'(wordCount), 64'(n));
    check({name, "_overflow"}, 64'(overflow), 64'(ovf));
    check({name, "_busy_idle"}, 64'(busy), 64'(0));
    check({name, "_pending_writes"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int          n, d0, w0, rises;
    logic        prv;
    logic [29:0] s, e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 64'({pX_mem_op, pX_read_write, busy, done, overflow}), 64'(5'b01000));
    check("reset_addr", 64'(pX_addr), 64'(0));
    check("reset_data", 64'(pX_data_out), 64'(0));
    check("reset_count", 64'(wordCount), 64'(0));
    tick();
    reset = 1'b0;
    tick();

    // Basic four-word run, with an ignored IDLE strobe and an ignored re-start while busy.
    send(32'hDEAD_BEEF);
    d0 = dones_seen;
    w0 = writes_seen;
    words = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    predict(64'h100, 64'h10C, 99, n);
    start_run(30'h100, 30'h10C);
    check("t1_busy", 64'(busy), 64'(1));
    send(words[0]);
    send(words[1]);
    writeAddrStart = 30'h900;
    writeAddrEnd = 30'h9FC;
    cntrlWriteData = 1'b1;
    send(words[2]);
    cntrlWriteData = 1'b0;
    send(words[3]);
    wait_done("t1", 200, d0);
    finish_checks("t1", n, 1'b0, d0);
    check("t1_writes", 64'(writes_seen - w0), 64'(4));

    // Overflow with the memory port stalled, then drain exactly the buffered words.
    ready_set = 1'b0;
    d0 = dones_seen;
    words = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5};
    predict(64'h200, 64'h2FC, 4, n);
    start_run(30'h200, 30'h2FC);
    foreach (words[i]) send(words[i]);
    check("t2_overflow_set", 64'(overflow), 64'(1));
    w0 = writes_seen;
    repeat (10) tick();
    check("t2_no_write_stalled", 64'(writes_seen - w0), 64'(0));
    ready_set = 1'b1;
    for (int k = 0; k < 100 && writes_seen - w0 < 4; k++) tick();
    repeat (20) tick();
    check("t2_exactly_four", 64'(writes_seen - w0), 64'(4));
    cntrlAbort = 1'b1;
    wait_done("t2", 50, d0);
    cntrlAbort = 1'b0;
    finish_checks("t2", n, 1'b1, d0);

    // End below start: no writes, done in the second cycle after the start cycle.
    d0 = dones_seen;
    w0 = writes_seen;
    start_run(30'h100, 30'h0FC);
    check("t3_done_cycle1", 64'(done), 64'(0));
    tick();
    check("t3_done_cycle2", 64'(done), 64'(1));
    wait_done("t3", 20, d0);
    finish_checks("t3", 0, 1'b0, d0);
    check("t3_no_writes", 64'(writes_seen - w0), 64'(0));

    // Abort raised in the first request cycle of word 2.
    d0 = dones_seen;
    words = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    predict(64'h300, 64'h31C, 2, n);
    start_run(30'h300, 30'h31C);
    rises = 0;
    prv = 1'b0;
    for (int k = 0; k < 200 && rises < 2; k++) begin
      rx_data_ready = k < 4;
      rx_data_in = words[k % 4];
      tick();
      if (pX_mem_op && !prv) rises++;
      prv = pX_mem_op;
    end
    rx_data_ready = 1'b0;
    check("t4_second_write_seen", 64'(rises), 64'(2));
    cntrlAbort = 1'b1;
    wait_done("t4", 50, d0);
    cntrlAbort = 1'b0;
    finish_checks("t4", n, 1'b0, d0);

    // End address above the legal maximum is clamped.
    d0 = dones_seen;
    words = '{32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hD4};
    predict(64'd16777204, 64'h3FFFFFFF, 99, n);
    start_run(30'd16777204, 30'h3FFFFFFF);
    foreach (words[i]) send(words[i]);
    wait_done("t5", 100, d0);
    finish_checks("t5", n, 1'b0, d0);

    // Reset while waiting for the port, then a normal run.
    d0 = dones_seen;
    words = '{32'hE0, 32'hE1};
    predict(64'h400, 64'h40C, 99, n);
    start_run(30'h400, 30'h40C);
    send(words[0]);
    send(words[1]);
    for (int k = 0; k < 50 && !pX_mem_op; k++) tick();
    check("t6_in_write", 64'(pX_mem_op), 64'(1));
    ready_set = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("t6_reset_ctrl", 64'({pX_mem_op, pX_read_write, busy, done, overflow}), 64'(5'b01000));
    check("t6_reset_addr", 64'(pX_addr), 64'(0));
    check("t6_reset_data", 64'(pX_data_out), 64'(0));
    check("t6_reset_count", 64'(wordCount), 64'(0));
    tick();
    reset = 1'b0;
    exp_q.delete();
    ready_set = 1'b1;
    repeat (5) tick();
    check("t6_no_done", 64'(dones_seen - d0), 64'(0));
    d0 = dones_seen;
    words = '{32'hF0, 32'hF1};
    predict(64'h500, 64'h504, 99, n);
    start_run(30'h500, 30'h504);
    send(words[0]);
    send(words[1]);
    wait_done("t6b", 100, d0);
    finish_checks("t6b", n, 1'b0, d0);

    // Randomised runs with a jittery memory port; at most FIFO_DEPTH words per run.
    rnd_ready = 1'b1;
    for (int r = 0; r < 24; r++) begin
      int len, tot;
      len = int'($urandom_range(0, 4));
      tot = len + int'($urandom_range(0, 4 - len));
      s = 30'(longint'($urandom_range(16, 'h3FFFF)) * 4);
      e = len > 0 ? 30'(longint'(s) + 4 * (len - 1) + $urandom_range(0, 3))
                  : 30'(longint'(s) - 1 - $urandom_range(0, 8));
      words.delete();
      for (int i = 0; i < tot; i++) words.push_back($urandom);
      d0 = dones_seen;
      predict(longint'(s), longint'(e), 99, n);
      start_run(s, e);
      foreach (words[i]) begin
        repeat ($urandom_range(0, 2)) tick();
        send(words[i]);
      end
      wait_done("rnd", 400, d0);
      finish_checks("rnd", n, 1'b0, d0);
    end
    rnd_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
